writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the core.
- Accepts retiring instructions from the memory stage over a valid/ready handshake, waits for load data where needed, and sign/zero-extends and aligns loads.
- Drives the register file write port (wren, rdin, rd_data_in) from registered outputs.
- The register file writes on the clock edge, so a same-cycle read does not see the write. This stage therefore exposes a forwarding tap to decode, and keeps a retire counter and sticky error flags.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
RET_W, 32, retire counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept; combinational, = (state==IDLE)
in_rd  input  RA_W  destination register
in_rd_we  input  1  instruction writes rd
in_wb_sel  input  2  0=ALU result, 1=load data, 2=PC+4, 3=immediate
in_alu_result  input  XLEN  ALU result; for loads, the byte address
in_pc  input  XLEN  instruction PC
in_imm  input  XLEN  immediate (LUI)
in_funct3  input  3  load type
mem_rvalid  input  1  load data valid, single-cycle pulse
mem_rdata  input  XLEN  raw aligned word from data memory
rf_wren  output  1  register file write enable
rf_rd  output  RA_W  register file write address
rf_wdata  output  XLEN  register file write data
fwd_valid  output  1  = rf_wren
fwd_rd  output  RA_W  = rf_rd
fwd_data  output  XLEN  = rf_wdata
retire_count  output  RET_W  instructions completed
err_misaligned  output  1  sticky: misaligned or illegal load
err_spurious  output  1  sticky: mem_rvalid while not waiting

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rf_wren=0, rf_rd=0, rf_wdata=0, retire_count=0, both error flags=0.
  - Any pending load is discarded.
- Acceptance: on an edge with in_valid & in_ready, capture rd, rd_we, wb_sel, alu_result[1:0], pc, imm, funct3, alu_result.
- Non-load (wb_sel != 1):
  - Completes on the capture edge; state stays IDLE.
  - rf_* are valid in the following cycle (latency 1).
  - Data: sel 0 = alu_result, sel 2 = pc+4 (mod 2^XLEN), sel 3 = imm.
  - Back-to-back acceptance every cycle is supported.
- Load (wb_sel==1):
  - Capture edge moves state IDLE -> WAIT_MEM; in_ready=0 while in WAIT_MEM.
  - On the first edge with mem_rvalid=1 in WAIT_MEM: complete, state -> IDLE, rf_* valid the next cycle.
  - mem_rvalid in the same cycle as acceptance is not consumed; the earliest consumption is the cycle after capture.
- Load extraction uses offset = alu_result[1:0]:
  - LB 000: byte[offset], sign-extended.
  - LBU 100: byte[offset], zero-extended.
  - LH 001: halfword at offset 0 or 2, sign-extended.
  - LHU 101: halfword at offset 0 or 2, zero-extended.
  - LW 010: offset 0 only.
- Illegal loads: LH/LHU with odd offset, LW with nonzero offset, or funct3 in {011,110,111}.
  - Still wait for mem_rvalid and retire normally.
  - rf_wren=0 on completion; err_misaligned set (sticky until reset).
- Write enable on completion: rf_wren = rd_we & (rd != 0) & !illegal. Otherwise rf_wren=0, but rf_rd and rf_wdata still update.
- rf_wren is high for exactly one cycle per completing instruction. When no completion occurs on an edge, rf_wren=0 and rf_rd/rf_wdata hold their values.
- retire_count increments by 1 on every completion edge, including rd=0, rd_we=0 and illegal loads. It wraps from 2^RET_W-1 to 0.
- mem_rvalid while state==IDLE: ignored, err_spurious set (sticky).
- Reset asserted in WAIT_MEM: immediate return to IDLE; the load never writes.

Test Plan:
- ALU ops back-to-back: accept rd=5 alu=0x12345678, then rd=6 alu=0xCAFEF00D on consecutive cycles -> rf_wren high two consecutive cycles, (5,0x12345678) then (6,0xCAFEF00D); in_ready stays 1; retire_count=2.
- Loads from mem_rdata=0x80FF7F01 with rd=7:
  - LB offset 2 -> 0xFFFFFFFF.
  - LBU offset 3 -> 0x00000080.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
  - LW offset 0 -> 0x80FF7F01.
  - mem_rvalid delayed 3 cycles -> in_ready low for exactly those cycles; write follows 1 cycle after the mem_rvalid edge.
- rd=0 with rd_we=1 and alu=0xDEADBEEF, JAL sel=2 pc=0xFFFFFFFC -> first: rf_wren=0 and retire_count increments; second (rd=1): rf_wdata=0x00000000.
- LW offset 1, then LH offset 3 -> rf_wren never asserted; err_misaligned=1 after the first and stays 1; retire_count +2.
- rst_n pulsed low in WAIT_MEM, then mem_rvalid pulsed -> no write, all outputs 0, err_spurious=1.
- Preload retire_count to 2^RET_W-1 (force, or RET_W=4 after 15 ops) and retire one more -> count=0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Bundle between memory stage, data memory, register file and decode forwarding tap.
// The master drives retiring instructions and load data; the slave is the writeback stage.
interface writeback_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned RET_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [RA_W-1:0]   in_rd;
    logic              in_rd_we;
    logic [1:0]        in_wb_sel;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic [2:0]        in_funct3;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              rf_wren;
    logic [RA_W-1:0]   rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              fwd_valid;
    logic [RA_W-1:0]   fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic [RET_W-1:0]  retire_count;
    logic              err_misaligned;
    logic              err_spurious;

    modport master (
        output in_valid, in_rd, in_rd_we, in_wb_sel, in_alu_result, in_pc, in_imm, in_funct3,
        output mem_rvalid, mem_rdata,
        input  in_ready, rf_wren, rf_rd, rf_wdata, fwd_valid, fwd_rd, fwd_data,
        input  retire_count, err_misaligned, err_spurious
    );

    modport slave (
        input  in_valid, in_rd, in_rd_we, in_wb_sel, in_alu_result, in_pc, in_imm, in_funct3,
        input  mem_rvalid, mem_rdata,
        output in_ready, rf_wren, rf_rd, rf_wdata, fwd_valid, fwd_rd, fwd_data,
        output retire_count, err_misaligned, err_spurious
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions, waits for and formats load data,
// drives the register file write port from registers and exposes a forwarding tap.
module writeback_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned RET_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    writeback_stage_if.slave bus
);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StWaitMem = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [RA_W-1:0]  ld_rd_q, ld_rd_d;
    logic             ld_we_q, ld_we_d;
    logic [2:0]       ld_funct3_q, ld_funct3_d;
    logic [1:0]       ld_off_q, ld_off_d;

    logic             rf_wren_q, rf_wren_d;
    logic [RA_W-1:0]  rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [RET_W-1:0] retire_q, retire_d;
    logic             mis_q, mis_d;
    logic             spur_q, spur_d;

    logic             complete;
    logic             accept;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_data;
    logic             ld_illegal;
    logic [XLEN-1:0]  sel_data;

    assign bus.in_ready = (state_q == StIdle);
    assign accept       = bus.in_valid & bus.in_ready;

    // Load formatting works on the captured offset, not the live bus.
    always_comb begin
        ld_byte    = bus.mem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half    = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_data    = bus.mem_rdata;
        ld_illegal = 1'b0;
        case (ld_funct3_q)
            3'b000: ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                ld_data    = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_illegal = ld_off_q[0];
            end
            3'b101: begin
                ld_data    = {{(XLEN-16){1'b0}}, ld_half};
                ld_illegal = ld_off_q[0];
            end
            3'b010:  ld_illegal = (ld_off_q != 2'b00);
            default: ld_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.in_wb_sel)
            2'd2:    sel_data = bus.in_pc + XLEN'(4);
            2'd3:    sel_data = bus.in_imm;
            default: sel_data = bus.in_alu_result;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        rf_wren_d   = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        mis_d       = mis_q;
        spur_d      = spur_q;
        complete    = 1'b0;

        if (state_q == StIdle) begin
            // A same-cycle mem_rvalid is never the answer to the load being accepted now.
            if (bus.mem_rvalid) begin
                spur_d = 1'b1;
            end
            if (accept) begin
                if (bus.in_wb_sel == 2'd1) begin
                    state_d     = StWaitMem;
                    ld_rd_d     = bus.in_rd;
                    ld_we_d     = bus.in_rd_we;
                    ld_funct3_d = bus.in_funct3;
                    ld_off_d    = bus.in_alu_result[1:0];
                end else begin
                    complete   = 1'b1;
                    rf_rd_d    = bus.in_rd;
                    rf_wdata_d = sel_data;
                    rf_wren_d  = bus.in_rd_we & (bus.in_rd != '0);
                end
            end
        end else if (bus.mem_rvalid) begin
            state_d    = StIdle;
            complete   = 1'b1;
            rf_rd_d    = ld_rd_q;
            rf_wdata_d = ld_data;
            rf_wren_d  = ld_we_q & (ld_rd_q != '0) & ~ld_illegal;
            if (ld_illegal) begin
                mis_d = 1'b1;
            end
        end

        retire_d = retire_q + RET_W'(complete);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ld_rd_q     <= '0;
            ld_we_q     <= 1'b0;
            ld_funct3_q <= 3'b000;
            ld_off_q    <= 2'b00;
            rf_wren_q   <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
            retire_q    <= '0;
            mis_q       <= 1'b0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            rf_wren_q   <= rf_wren_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            retire_q    <= retire_d;
            mis_q       <= mis_d;
            spur_q      <= spur_d;
        end
    end

    assign bus.rf_wren        = rf_wren_q;
    assign bus.rf_rd          = rf_rd_q;
    assign bus.rf_wdata       = rf_wdata_q;
    assign bus.fwd_valid      = rf_wren_q;
    assign bus.fwd_rd         = rf_rd_q;
    assign bus.fwd_data       = rf_wdata_q;
    assign bus.retire_count   = retire_q;
    assign bus.err_misaligned = mis_q;
    assign bus.err_spurious   = spur_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/JAL/LUI retires, load formatting, illegal loads,
// reset during a pending load, spurious load data and retire counter wrap (RET_W = 4).
module tb_writeback_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned RET_W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [RET_W-1:0] exp_cnt;

    writeback_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .RET_W(RET_W)) bus ();

    writeback_stage #(.XLEN(XLEN), .RA_W(RA_W), .RET_W(RET_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [RA_W-1:0] rd, input logic we, input logic [1:0] sel,
                            input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc,
                            input logic [XLEN-1:0] imm, input logic [2:0] f3);
        bus.in_valid      = 1'b1;
        bus.in_rd         = rd;
        bus.in_rd_we      = we;
        bus.in_wb_sel     = sel;
        bus.in_alu_result = alu;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_funct3     = f3;
    endtask

    // Accept a load for rd=7, hold off mem_rvalid for 'delay' cycles, then check the result.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input int delay, input logic [XLEN-1:0] rdata,
                           input logic exp_wren, input logic chk_data,
                           input logic [XLEN-1:0] exp_data);
        drive_op(5'd7, 1'b1, 2'd1, {30'h0000_1000, off}, '0, '0, f3);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            check({tag, "_wait_ready"}, bus.in_ready, 1'b0);
            check({tag, "_wait_wren"}, bus.rf_wren, 1'b0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        check({tag, "_rv_ready"}, bus.in_ready, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
        exp_cnt++;
        check({tag, "_wren"}, bus.rf_wren, exp_wren);
        check({tag, "_rd"}, bus.rf_rd, 5'd7);
        if (chk_data) check({tag, "_data"}, bus.rf_wdata, exp_data);
        check({tag, "_ready"}, bus.in_ready, 1'b1);
        check({tag, "_cnt"}, bus.retire_count, exp_cnt);
        tick();
        check({tag, "_wren_pulse"}, bus.rf_wren, 1'b0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        exp_cnt = '0;
        rst_n   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rd = '0; bus.in_rd_we = 1'b0; bus.in_wb_sel = 2'd0;
        bus.in_alu_result = '0; bus.in_pc = '0; bus.in_imm = '0; bus.in_funct3 = 3'b000;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        #12;
        check("rst_wren", bus.rf_wren, 1'b0);
        check("rst_rd", bus.rf_rd, 5'd0);
        check("rst_data", bus.rf_wdata, 32'h0);
        check("rst_cnt", bus.retire_count, 4'd0);
        check("rst_mis", bus.err_misaligned, 1'b0);
        check("rst_spur", bus.err_spurious, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU ops
        drive_op(5'd5, 1'b1, 2'd0, 32'h1234_5678, '0, '0, 3'b000);
        tick();
        exp_cnt++;
        check("alu0_wren", bus.rf_wren, 1'b1);
        check("alu0_rd", bus.rf_rd, 5'd5);
        check("alu0_data", bus.rf_wdata, 32'h1234_5678);
        check("alu0_fwd", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, {1'b1, 5'd5, 32'h1234_5678});
        check("alu0_ready", bus.in_ready, 1'b1);
        drive_op(5'd6, 1'b1, 2'd0, 32'hCAFE_F00D, '0, '0, 3'b000);
        tick();
        exp_cnt++;
        bus.in_valid = 1'b0;
        check("alu1_wren", bus.rf_wren, 1'b1);
        check("alu1_rd", bus.rf_rd, 5'd6);
        check("alu1_data", bus.rf_wdata, 32'hCAFE_F00D);
        check("alu1_cnt", bus.retire_count, 4'd2);
        tick();
        check("idle_wren", bus.rf_wren, 1'b0);
        check("idle_hold", {bus.rf_rd, bus.rf_wdata}, {5'd6, 32'hCAFE_F00D});

        // Load formatting from 0x80FF7F01
        do_load("lb2", 3'b000, 2'd2, 0, 32'h80FF_7F01, 1'b1, 1'b1, 32'hFFFF_FFFF);
        do_load("lbu3", 3'b100, 2'd3, 0, 32'h80FF_7F01, 1'b1, 1'b1, 32'h0000_0080);
        do_load("lh2", 3'b001, 2'd2, 1, 32'h80FF_7F01, 1'b1, 1'b1, 32'hFFFF_80FF);
        do_load("lhu0", 3'b101, 2'd0, 0, 32'h80FF_7F01, 1'b1, 1'b1, 32'h0000_7F01);
        do_load("lw0", 3'b010, 2'd0, 3, 32'h80FF_7F01, 1'b1, 1'b1, 32'h80FF_7F01);

        // rd=0, JAL wrap, LUI, rd_we=0
        drive_op(5'd0, 1'b1, 2'd0, 32'hDEAD_BEEF, '0, '0, 3'b000);
        tick();
        exp_cnt++;
        check("x0_wren", bus.rf_wren, 1'b0);
        check("x0_data", bus.rf_wdata, 32'hDEAD_BEEF);
        check("x0_cnt", bus.retire_count, exp_cnt);
        drive_op(5'd1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, '0, 3'b000);
        tick();
        exp_cnt++;
        check("jal_wren", bus.rf_wren, 1'b1);
        check("jal_data", bus.rf_wdata, 32'h0000_0000);
        drive_op(5'd3, 1'b1, 2'd3, 32'h1, 32'h10, 32'hABCD_E000, 3'b000);
        tick();
        exp_cnt++;
        check("lui_data", bus.rf_wdata, 32'hABCD_E000);
        drive_op(5'd4, 1'b0, 2'd0, 32'h5555_AAAA, '0, '0, 3'b000);
        tick();
        exp_cnt++;
        bus.in_valid = 1'b0;
        check("nowe_wren", bus.rf_wren, 1'b0);
        check("nowe_rd", bus.rf_rd, 5'd4);
        check("nowe_cnt", bus.retire_count, exp_cnt);

        // Illegal loads
        check("mis_pre", bus.err_misaligned, 1'b0);
        do_load("lw1", 3'b010, 2'd1, 0, 32'h1111_2222, 1'b0, 1'b0, '0);
        check("mis_lw1", bus.err_misaligned, 1'b1);
        do_load("lh3", 3'b001, 2'd3, 1, 32'h1111_2222, 1'b0, 1'b0, '0);
        check("mis_lh3", bus.err_misaligned, 1'b1);
        do_load("f3_011", 3'b011, 2'd0, 0, 32'h1111_2222, 1'b0, 1'b0, '0);
        check("spur_none", bus.err_spurious, 1'b0);

        // Reset while a load is pending, then a stray mem_rvalid
        drive_op(5'd7, 1'b1, 2'd1, 32'h0, '0, '0, 3'b010);
        tick();
        bus.in_valid = 1'b0;
        check("pend_ready", bus.in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_ready", bus.in_ready, 1'b1);
        check("mrst_out", {bus.rf_wren, bus.rf_rd, bus.rf_wdata}, 38'h0);
        check("mrst_cnt", bus.retire_count, 4'd0);
        check("mrst_err", {bus.err_misaligned, bus.err_spurious}, 2'b00);
        #1 rst_n = 1'b1;
        exp_cnt = '0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        tick();
        bus.mem_rvalid = 1'b0;
        check("stray_wren", bus.rf_wren, 1'b0);
        check("stray_out", {bus.rf_rd, bus.rf_wdata}, 37'h0);
        check("stray_cnt", bus.retire_count, 4'd0);
        check("stray_spur", bus.err_spurious, 1'b1);
        check("stray_ready", bus.in_ready, 1'b1);

        // mem_rvalid coincident with acceptance is not consumed
        drive_op(5'd9, 1'b1, 2'd1, 32'h0000_2001, '0, '0, 3'b100);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h80FF_7F01;
        tick();
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("coin_ready", bus.in_ready, 1'b0);
        check("coin_wren", bus.rf_wren, 1'b0);
        check("coin_cnt", bus.retire_count, 4'd0);
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        exp_cnt++;
        check("coin_done", {bus.rf_wren, bus.rf_rd, bus.rf_wdata}, {1'b1, 5'd9, 32'h0000_007F});
        check("coin_cnt2", bus.retire_count, exp_cnt);

        // Retire counter wrap
        for (int i = 0; i < 14; i++) begin
            drive_op(5'd2, 1'b1, 2'd0, 32'(i), '0, '0, 3'b000);
            tick();
            exp_cnt++;
        end
        check("wrap_pre", bus.retire_count, 4'd15);
        drive_op(5'd2, 1'b1, 2'd0, 32'h0000_00AA, '0, '0, 3'b000);
        tick();
        exp_cnt++;
        bus.in_valid = 1'b0;
        check("wrap_cnt", bus.retire_count, 4'd0);
        check("wrap_data", bus.rf_wdata, 32'h0000_00AA);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
